alu_multicycle: RTL
===================

// Module: alu_multicycle
// PURPOSE
//   Parametrised successor ALU for the datapath. Adds a registered valid/ready
//   handshake, four more ops (OR, XOR, LSL, MUL) and an iterative multiplier.
//   Sits between the register-file read stage and the writeback mux.
//   Operands are captured on accept; result and flags are held until consumed.
// PARAMETERS
//   WIDTH   16   operand/result width in bits; legal range 4..64
//   (local) SHW = $clog2(WIDTH), shift-amount width
// PORTS
//   clk        in   1        single clock; all state updates on posedge
//   rst_n      in   1        asynchronous, active-low reset
//   in_valid   in   1        request valid
//   in_ready   out  1        block can accept a request
//   Ain        in   WIDTH    operand A
//   Bin        in   WIDTH    operand B
//   ALUop      in   3        000 ADD, 001 SUB, 010 AND, 011 NOT(~Bin),
//                            100 OR, 101 XOR, 110 LSL, 111 MUL
//   out_valid  out  1        result valid
//   out_ready  in   1        consumer takes result
//   out        out  WIDTH    registered result
//   outFlag    out  FW       {V,N,Z}; FW=3, or 4 with carry (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (async, rst_n=0): state IDLE, out=0, outFlag=0, out_valid=0,
//     in_ready=1. Effect is immediate; an in-flight op (including MUL) is discarded.
//   - FSM: IDLE -accept-> EXEC (non-MUL) or MUL; EXEC -1 cycle-> DONE;
//     MUL -WIDTH cycles-> DONE; DONE -out_ready-> IDLE.
//   - in_ready = (state==IDLE). Accept = in_valid & in_ready.
//     Ain, Bin and ALUop are latched on accept; later changes are ignored.
//   - Latency from the accept edge to out_valid=1: 1 cycle for non-MUL ops,
//     WIDTH+1 cycles for MUL.
//   - DONE: out_valid=1. out and outFlag stay stable until out_ready=1.
//     in_ready=0 in DONE. When out_ready=1 in DONE, the next state is IDLE and
//     out_valid=0 in the next cycle. out and outFlag keep their last values.
//   - Arithmetic is modulo 2^WIDTH. SUB = A + ~B + 1.
//     LSL = A << Bin[SHW-1:0]; higher Bin bits are ignored.
//   - MUL: unsigned shift-add, one Bin bit per cycle (LSB first) into a
//     2*WIDTH accumulator. out = low WIDTH bits of the product.
//   - Z = (out==0). N = out[WIDTH-1].
//   - V: signed overflow for ADD/SUB (carry into MSB XOR carry out of MSB).
//     For MUL, V=1 when the upper WIDTH product bits are nonzero. V=0 for all
//     other ops.
//   - Illegal states decode to IDLE.
// CONFIGURATION
//   ALU_CARRY_FLAG_EN defined:
//     FW=4, outFlag={C,V,N,Z}.
//     C = carry out of the MSB for ADD, C = not-borrow for SUB, C = 0 otherwise.
//     C resets to 0.
//   ALU_CARRY_FLAG_EN undefined:
//     FW=3, outFlag={V,N,Z}. No carry logic is synthesised.
// TESTING (WIDTH=16 unless stated)
//   1. ADD 7FFF+0001 -> out=8000, outFlag=3'b110, out_valid 1 cycle after accept.
//   2. SUB 0005-0005 -> out=0000, outFlag=3'b001.
//      AND F0F0&FF00 -> out=F000, outFlag=3'b010.
//   3. MUL 0100*0100 -> out=0000, outFlag=3'b101, out_valid 17 cycles after
//      accept, in_ready=0 throughout.
//   4. Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with
//      new operands -> out/outFlag stable, in_ready=0, no new accept. Release
//      out_ready -> IDLE next cycle, then the new request is accepted.
//   5. Assert rst_n=0 at cycle 8 of a MUL -> out_valid=0, out=0, outFlag=0,
//      in_ready=1 without waiting for a clock. After release, a fresh ADD 0001+0001
//      returns 0002.
//   6. ALU_CARRY_FLAG_EN: ADD FFFF+0001 -> out=0000, outFlag=4'b1001.
//      Same op without the macro -> outFlag=3'b001.
//      LSL 0001 by Bin=0013 -> out=0008 (only Bin[3:0] used).

Source files
------------

// File: rtl/alu_multicycle.sv
// alu_multicycle: multi-cycle ALU with a valid/ready handshake on both sides.
// Ops: ADD SUB AND NOT OR XOR LSL MUL. MUL is an iterative shift-add multiplier
// that consumes one bit of Bin per cycle.
// Optional macro ALU_CARRY_FLAG_EN: widens outFlag to {C,V,N,Z}; without it
// outFlag is {V,N,Z} and no carry register exists.
module alu_multicycle #(
  parameter int WIDTH = 16,
`ifdef ALU_CARRY_FLAG_EN
  localparam int FW = 4
`else
  localparam int FW = 3
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  input  logic [2:0]       ALUop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [FW-1:0]    outFlag
);
  localparam int SHW  = $clog2(WIDTH);
  localparam int CNTW = SHW + 1;

  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010,
                         OP_NOT = 3'b011, OP_OR  = 3'b100, OP_XOR = 3'b101,
                         OP_LSL = 3'b110, OP_MUL = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;
  state_t r_state, w_next;

  logic [WIDTH-1:0]   r_a, r_b, r_out;
  logic [2:0]         r_op;
  logic [2*WIDTH-1:0] r_acc, r_mcand;
  logic [CNTW-1:0]    r_cnt;
  logic               r_v, r_n, r_z;
`ifdef ALU_CARRY_FLAG_EN
  logic               r_c;
`endif

  logic               w_accept, w_mul_last, w_fin;
  logic [WIDTH-1:0]   w_bop, w_res;
  logic [WIDTH:0]     w_sum;
  logic               w_c, w_v;

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign w_accept   = in_valid & in_ready;
  assign w_mul_last = (r_cnt == CNTW'(WIDTH));
  // Result and flags are written once: at the end of EXEC, or after the last MUL bit.
  assign w_fin      = (r_state == S_EXEC) | ((r_state == S_MUL) & w_mul_last);

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; the unused encoding space falls back to IDLE.
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE: begin
        w_next = S_IDLE;
        if (in_valid) w_next = (ALUop == OP_MUL) ? S_MUL : S_EXEC;
      end
      S_EXEC: w_next = S_DONE;
      S_MUL:  w_next = w_mul_last ? S_DONE : S_MUL;
      S_DONE: w_next = out_ready ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // Shared adder: SUB is A + ~B + 1, so the carry out is the not-borrow.
  always_comb begin
    w_bop = (r_op == OP_SUB) ? ~r_b : r_b;
    w_sum = {1'b0, r_a} + {1'b0, w_bop} + {{WIDTH{1'b0}}, (r_op == OP_SUB)};
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (r_op)
      OP_ADD, OP_SUB: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        // carry into MSB xor carry out of MSB
        w_v   = (r_a[WIDTH-1] ^ w_bop[WIDTH-1] ^ w_sum[WIDTH-1]) ^ w_sum[WIDTH];
      end
      OP_AND: w_res = r_a & r_b;
      OP_NOT: w_res = ~r_b;
      OP_OR:  w_res = r_a | r_b;
      OP_XOR: w_res = r_a ^ r_b;
      OP_LSL: w_res = r_a << r_b[SHW-1:0];
      OP_MUL: begin
        w_res = r_acc[WIDTH-1:0];
        w_v   = |r_acc[2*WIDTH-1:WIDTH];
      end
      default: w_res = '0;
    endcase
  end

  // Operand capture on accept and the shift-add multiply iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= OP_ADD;
      r_acc   <= '0;
      r_mcand <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= Ain;
      r_b     <= Bin;
      r_op    <= ALUop;
      r_acc   <= '0;
      r_mcand <= {{WIDTH{1'b0}}, Ain};
      r_cnt   <= '0;
    end else if ((r_state == S_MUL) && !w_mul_last) begin
      if (r_b[0]) r_acc <= r_acc + r_mcand;
      r_mcand <= r_mcand << 1;
      r_b     <= r_b >> 1;
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  // Result/flag registers; they hold through DONE and after the result is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
      r_v   <= 1'b0;
      r_n   <= 1'b0;
      r_z   <= 1'b0;
`ifdef ALU_CARRY_FLAG_EN
      r_c   <= 1'b0;
`endif
    end else if (w_fin) begin
      r_out <= w_res;
      r_v   <= w_v;
      r_n   <= w_res[WIDTH-1];
      r_z   <= (w_res == '0);
`ifdef ALU_CARRY_FLAG_EN
      r_c   <= w_c;
`endif
    end
  end

  assign out = r_out;
`ifdef ALU_CARRY_FLAG_EN
  assign outFlag = {r_c, r_v, r_n, r_z};
`else
  assign outFlag = {r_v, r_n, r_z};
  logic w_unused_c;
  assign w_unused_c = w_c;
`endif

endmodule
